// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter stage.
//   pc_state_t     - run-control states (BOOT, RUN, HALTED)
//   pc_sel_t       - next-PC source select
//   BRANCH_COUNT_W - width of the optional taken-redirect counter
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_BRANCH,
        SEL_JUMP
    } pc_sel_t;

    localparam int BRANCH_COUNT_W = 16;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC selection for pc_unit.
// Ports:
//   run       in  1  state is RUN
//   wake      in  1  state is HALTED and resume is requested
//   en        in  1  global advance enable
//   halt      in  1  decoder HALT
//   jump      in  1  decoder absolute jump
//   branch_lt in  1  decoder branch-if-less-than
//   LT        in  1  comparator result
//   offset    in  n  signed branch displacement
//   target    in  n  absolute jump address
//   pc        in  n  current PC
//   pc_next   out n  value PC takes at the next edge
//   taken     out 1  branch or jump redirect this cycle
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         run,
    input  logic         wake,
    input  logic         en,
    input  logic         halt,
    input  logic         jump,
    input  logic         branch_lt,
    input  logic         LT,
    input  logic [n-1:0] offset,
    input  logic [n-1:0] target,
    input  logic [n-1:0] pc,
    output logic [n-1:0] pc_next,
    output logic         taken
);

    localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

    pc_sel_t sel;

    always_comb begin
        sel = SEL_HOLD;
        if (en) begin
            if (wake) begin
                sel = SEL_INC;
            end else if (run) begin
                if (halt)
                    sel = SEL_HOLD;
                else if (jump)
                    sel = SEL_JUMP;
                else if (branch_lt && LT)
                    sel = SEL_BRANCH;
                else
                    sel = SEL_INC;
            end
        end
    end

    // An n-bit add of the raw offset is already sign-extended modulo 2^n.
    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_INC:    pc_next = pc + ONE;
            SEL_BRANCH: pc_next = pc + offset;
            SEL_JUMP:   pc_next = target;
            default:    pc_next = pc;
        endcase
    end

    assign taken = (sel == SEL_BRANCH) || (sel == SEL_JUMP);

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter register with BOOT/RUN/HALTED run control.
// Optional feature macro: PC_BRANCH_COUNT_EN adds a saturating 16-bit
// count of taken branches/jumps on output branch_count.
// Ports:
//   clock, reset (async, active high)
//   en, branch_lt, LT, jump, offset[n], target[n], halt, resume  inputs
//   PC[n], pc_next[n], taken, halted                             outputs
//   branch_count[16]                      output, PC_BRANCH_COUNT_EN only
//
// state  | meaning
// BOOT   | first edge after reset, PC held at RESET_VEC
// RUN    | executing, PC advances when en = 1
// HALTED | stopped on HALT, waits for resume with en
module pc_unit
    import pc_pkg::*;
#(
    parameter int           n         = 8,
    parameter logic [n-1:0] RESET_VEC = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      branch_lt,
    input  logic                      LT,
    input  logic                      jump,
    input  logic [n-1:0]              offset,
    input  logic [n-1:0]              target,
    input  logic                      halt,
    input  logic                      resume,
    output logic [n-1:0]              PC,
    output logic [n-1:0]              pc_next,
    output logic                      taken,
`ifdef PC_BRANCH_COUNT_EN
    output logic [BRANCH_COUNT_W-1:0] branch_count,
`endif
    output logic                      halted
);

    pc_state_t state, state_next;

    pc_next_mux #(.n(n)) u_mux (
        .run       (state == RUN),
        .wake      ((state == HALTED) && resume),
        .en        (en),
        .halt      (halt),
        .jump      (jump),
        .branch_lt (branch_lt),
        .LT        (LT),
        .offset    (offset),
        .target    (target),
        .pc        (PC),
        .pc_next   (pc_next),
        .taken     (taken)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            PC    <= RESET_VEC;
        end else begin
            state <= state_next;
            PC    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (en && halt)   state_next = HALTED;
            HALTED:  if (en && resume) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    assign halted = (state == HALTED);

`ifdef PC_BRANCH_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            branch_count <= '0;
        else if (taken && en && (branch_count != {BRANCH_COUNT_W{1'b1}}))
            branch_count <= branch_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       en, branch_lt, LT, jump, halt, resume;
    logic [7:0] offset, target;
    logic [7:0] PC, pc_next;
    logic       taken, halted;
`ifdef PC_BRANCH_COUNT_EN
    logic [15:0] branch_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    pc_unit #(.n(8), .RESET_VEC(8'h00)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .branch_lt (branch_lt),
        .LT        (LT),
        .jump      (jump),
        .offset    (offset),
        .target    (target),
        .halt      (halt),
        .resume    (resume),
        .PC        (PC),
        .pc_next   (pc_next),
        .taken     (taken),
`ifdef PC_BRANCH_COUNT_EN
        .branch_count (branch_count),
`endif
        .halted    (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_in(input logic e, input logic bl, input logic lt, input logic j,
                          input logic h, input logic r, input logic [7:0] off,
                          input logic [7:0] tgt);
        en = e; branch_lt = bl; LT = lt; jump = j; halt = h; resume = r;
        offset = off; target = tgt;
    endtask

    // Called at posedge+1; leaves time at the next posedge+1.
    task automatic do_reset();
        set_in(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        #3 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_boot, m_halt;
    int m_pc, m_cnt;

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_pc = 0; m_cnt = 0;
    endtask

    function automatic void model_comb(output int nx, output bit tk);
        nx = m_pc; tk = 0;
        if (m_boot) begin
            nx = m_pc;
        end else if (m_halt) begin
            if (en && resume) nx = (m_pc + 1) % 256;
        end else if (en) begin
            if (halt) nx = m_pc;
            else if (jump) begin nx = int'(target); tk = 1; end
            else if (branch_lt && LT) begin
                nx = (m_pc + int'($signed(offset)) + 256) % 256; tk = 1;
            end else nx = (m_pc + 1) % 256;
        end
    endfunction

    task automatic model_edge(input int nx, input bit tk);
        if (m_boot) m_boot = 0;
        else if (m_halt) begin if (en && resume) m_halt = 0; end
        else if (en && halt) m_halt = 1;
        if (tk && en && m_cnt < 65535) m_cnt++;
        m_pc = nx;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       e, bl, lt, j, h, r;
        logic [7:0] off, tgt;
        logic [7:0] x_pc;
        logic       x_taken, x_halted;
    } vec_t;

    vec_t vt[19];

    initial begin
        int nx;
        bit tk;

        set_in(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        #2;
        check("reset_pc", int'(PC), 0);
        check("reset_halted", int'(halted), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;   // BOOT edge
        check("boot_pc", int'(PC), 0);

        //        e  bl lt j  h  r  off    tgt    pc     tk hl
        vt[0]  = '{1, 0, 0, 1, 0, 0, 8'h00, 8'hFE, 8'hFE, 1, 0};
        vt[1]  = '{1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 0};
        vt[2]  = '{1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0};
        vt[3]  = '{1, 0, 0, 1, 0, 0, 8'h00, 8'h10, 8'h10, 1, 0};
        vt[4]  = '{1, 1, 1, 0, 0, 0, 8'hFC, 8'h00, 8'h0C, 1, 0};
        vt[5]  = '{1, 0, 0, 1, 0, 0, 8'h00, 8'h10, 8'h10, 1, 0};
        vt[6]  = '{1, 1, 0, 0, 0, 0, 8'hFC, 8'h00, 8'h11, 0, 0};
        vt[7]  = '{1, 0, 0, 1, 0, 0, 8'h00, 8'h20, 8'h20, 1, 0};
        vt[8]  = '{1, 1, 1, 1, 0, 0, 8'h05, 8'h80, 8'h80, 1, 0};
        vt[9]  = '{1, 0, 0, 1, 1, 0, 8'h00, 8'h33, 8'h80, 0, 1};
        vt[10] = '{1, 0, 0, 1, 0, 0, 8'h00, 8'h44, 8'h80, 0, 1};
        vt[11] = '{1, 1, 1, 0, 0, 0, 8'h07, 8'h00, 8'h80, 0, 1};
        vt[12] = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h80, 0, 1};
        vt[13] = '{1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h81, 0, 0};
        vt[14] = '{1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h82, 0, 0};
        vt[15] = '{0, 0, 0, 1, 0, 0, 8'h00, 8'h55, 8'h82, 0, 0};
        vt[16] = '{1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h82, 1, 0};
        vt[17] = '{1, 1, 1, 0, 0, 0, 8'h7F, 8'h00, 8'h01, 1, 0};
        vt[18] = '{1, 1, 1, 0, 0, 0, 8'h80, 8'h00, 8'h81, 1, 0};

        for (int i = 0; i < 19; i++) begin
            set_in(vt[i].e, vt[i].bl, vt[i].lt, vt[i].j, vt[i].h, vt[i].r,
                   vt[i].off, vt[i].tgt);
            #1;
            check($sformatf("vec%0d_pc_next", i), int'(pc_next), int'(vt[i].x_pc));
            check($sformatf("vec%0d_taken", i), int'(taken), int'(vt[i].x_taken));
            @(posedge clock); #1;
            check($sformatf("vec%0d_pc", i), int'(PC), int'(vt[i].x_pc));
            check($sformatf("vec%0d_halted", i), int'(halted), int'(vt[i].x_halted));
        end

        // Reset mid-run from PC = 37, then the BOOT edge ignores a jump.
        set_in(1, 0, 0, 1, 0, 0, 8'h00, 8'h37);
        @(posedge clock); #1;
        check("pre_reset_pc", int'(PC), 8'h37);
        reset = 1'b1;
        #1;
        check("async_reset_pc", int'(PC), 0);
        #1 reset = 1'b0;
        set_in(1, 1, 1, 1, 1, 0, 8'h05, 8'h99);
        #1;
        check("boot_taken", int'(taken), 0);
        check("boot_pc_next", int'(pc_next), 0);
        @(posedge clock); #1;
        check("boot_edge_pc", int'(PC), 0);
        check("boot_edge_halted", int'(halted), 0);
        set_in(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        @(posedge clock); #1;
        check("run_first_pc", int'(PC), 1);

        // Randomized phase against the reference model.
        do_reset();
        model_reset();
        model_comb(nx, tk);
        model_edge(nx, tk);   // account for the BOOT edge inside do_reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                #1;
                check("rand_async_reset", int'(PC), 0);
                reset = 1'b0;
                model_reset();
            end
            set_in($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 2,
                   $urandom_range(0, 19) < 2, $urandom_range(0, 9) < 3,
                   8'($urandom), 8'($urandom));
            #1;
            model_comb(nx, tk);
            check("rand_pc_next", int'(pc_next), nx);
            check("rand_taken", int'(taken), int'(tk));
            @(posedge clock); #1;
            model_edge(nx, tk);
            check("rand_pc", int'(PC), m_pc);
            check("rand_halted", int'(halted), int'(m_halt));
`ifdef PC_BRANCH_COUNT_EN
            check("rand_count", int'(branch_count), m_cnt);
`endif
        end

`ifdef PC_BRANCH_COUNT_EN
        do_reset();
        check("cnt_reset", int'(branch_count), 0);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 1, 0, 0, 0, 8'h02, 8'h00);
            @(posedge clock); #1;
        end
        check("cnt_three", int'(branch_count), 3);
        check("cnt_three_pc", int'(PC), 6);
        set_in(0, 1, 1, 0, 0, 0, 8'h02, 8'h00);
        @(posedge clock); #1;
        check("cnt_en0", int'(branch_count), 3);
        check("cnt_en0_pc", int'(PC), 6);
        set_in(1, 1, 1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 65531; i++) @(posedge clock);
        #1;
        check("cnt_fffe", int'(branch_count), 16'hFFFE);
        @(posedge clock); #1;
        check("cnt_ffff", int'(branch_count), 16'hFFFF);
        @(posedge clock); #1;
        check("cnt_saturate", int'(branch_count), 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage of the single-cycle core; consumes the LT flag from the branch comparator plus decoder controls and produces the instruction-memory address.
- Holds the PC register and selects the next PC from four sources: hold, increment, relative branch, absolute jump.
- Contains a small run-control state machine: BOOT, RUN and HALTED.

Parameters:
- n, 8: PC, offset and target width in bits; all PC arithmetic is modulo 2^n.
- RESET_VEC, 0: PC value loaded on reset.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  global advance enable; when 0, all state holds.
- branch_lt  input  1  decoder: current instruction is branch-if-less-than.
- LT  input  1  comparator result, Rdata1 < Rdata2 (unsigned).
- jump  input  1  decoder: current instruction is an absolute jump.
- offset  input  n  signed two's-complement branch displacement, relative to the current PC.
- target  input  n  absolute jump address.
- halt  input  1  decoder: current instruction is HALT.
- resume  input  1  external request to leave HALTED.
- PC  output  n  current instruction address.
- pc_next  output  n  combinational next-PC value, for debug.
- taken  output  1  combinational: branch or jump taken this cycle.
- halted  output  1  registered: state is HALTED.

Behaviour:
- Reset (asynchronous assert, any state, including mid-halt):
  - PC = RESET_VEC, state = BOOT, halted = 0.
  - The optional counter clears to 0.
- BOOT:
  - Lasts exactly one clock edge after reset deasserts; PC holds at RESET_VEC.
  - Next state is RUN regardless of en or halt.
  - Decoder inputs are ignored; taken = 0.
- RUN, en = 1. Next PC uses fixed priority:
  1. halt: PC holds; state becomes HALTED; taken = 0.
  2. jump: PC = target; taken = 1.
  3. branch_lt and LT: PC = PC + sign_extend(offset), wrapping modulo 2^n; taken = 1.
  4. Otherwise: PC = PC + 1, wrapping from 2^n-1 to 0.
  - branch_lt with LT = 0 behaves as case 4; taken = 0.
- RUN, en = 0: PC and state hold; taken = 0.
- HALTED:
  - PC holds at the HALT instruction's address; halted = 1.
  - resume and en together: state becomes RUN and PC = PC + 1 on the same edge; halted drops on that edge.
  - halt, jump and branch inputs are ignored while HALTED.
  - resume asserted while in RUN is ignored.
- pc_next always equals the value PC will take at the next enabled edge; it equals PC in BOOT, HALTED and when en = 0.
- Latency:
  - A redirect (taken) takes effect on the next rising edge; there is no delay slot and no flush.
  - Zero-cycle combinational path from LT to pc_next.
- Offset arithmetic: offset is n bits signed. For n = 8 the range is -128..+127; an offset of 0 re-executes the same address.

Optional Feature:
- Macro: PC_BRANCH_COUNT_EN.
- Defined:
  - Adds output branch_count, 16 bits: a count of taken branches and jumps.
  - Increments on each edge where taken = 1 and en = 1.
  - Saturates at 16'hFFFF with no wrap.
  - Cleared by reset.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pc_pkg:
  - enum pc_state_t {BOOT, RUN, HALTED}.
  - enum pc_sel_t {SEL_HOLD, SEL_INC, SEL_BRANCH, SEL_JUMP}.
  - BRANCH_COUNT_W = 16.
- One natural sub-module, pc_next_mux: combinational priority select plus adders producing pc_next and taken.
- pc_unit keeps the register, the state machine and the optional counter.

Test Plan:
- Reset and boot: assert reset mid-run with PC = 8'h37 → PC = 0 immediately. After deassert, first edge PC = 0 (BOOT); second edge PC = 1.
- Increment wrap: run from PC = 8'hFE with no controls → PC = FF, then 00.
- Conditional branch: PC = 8'h10, branch_lt = 1, offset = 8'hFC:
  - LT = 1 → PC = 8'h0C, taken = 1.
  - LT = 0 → PC = 8'h11, taken = 0.
- Priority and jump: PC = 8'h20 with jump = 1, target = 8'h80, and branch_lt = LT = 1, offset = 5 → PC = 8'h80. Then halt = 1 and jump = 1 together → PC holds at 8'h80, halted = 1 next edge.
- Halt and resume: while HALTED, toggle jump and branch_lt → PC stays 8'h80. resume = 1 with en = 0 → no change. resume = 1 with en = 1 → PC = 8'h81, halted = 0.
- Enable gating and counter (PC_BRANCH_COUNT_EN defined):
  - 3 taken branches with en = 1 → branch_count = 3.
  - Taken condition with en = 0 → count and PC unchanged.
  - Force the count to FFFF, then take a branch → stays FFFF.
